// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC byte packer.
// The pair FSM states, the default filler byte and the drop counter width live here.
package adc_pkg;

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } pair_state_e;

    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;
    localparam int         DROP_CNT_W       = 16;

    // Saturating add used by the dropped-byte counter.
    function automatic logic [DROP_CNT_W-1:0] sat_add(
        input logic [DROP_CNT_W-1:0] a,
        input logic [1:0]            b
    );
        logic [DROP_CNT_W:0] s;
        s = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, b};
        return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/adc_byte_packer_if.sv
// Byte-in / word-out bus of the ADC byte packer.
// The slave modport is the packer itself; the master modport is whoever drives bytes and drains words.
interface adc_byte_packer_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       in_data;
    logic             in_valid;
    logic             flush;
    logic [15:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LVL_W-1:0] level;
    logic             ovf;
    logic             ovf_clr;

    modport master (
        output in_data, in_valid, flush, out_ready, ovf_clr,
        input  out_data, out_valid, level, ovf
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready, ovf_clr,
        output out_data, out_valid, level, ovf
    );

endinterface

// File: rtl/sync_word_fifo.sv
// Show-ahead 16-bit word FIFO with occupancy output.
// A write while full is only taken when a read retires the head in the same cycle.
module sync_word_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [15:0]                wr_data,
    input  logic                       rd_en,
    output logic [15:0]                rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_wr, do_rd;

    assign rd_valid = (level_q != '0);
    assign full     = (level_q == LW'(DEPTH));
    assign rd_data  = rd_valid ? mem_q[rptr_q] : 16'h0000;
    assign level    = level_q;

    assign do_rd = rd_en && rd_valid;
    assign do_wr = wr_en && (!full || do_rd);

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH by themselves.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
        if (do_wr && !do_rd) level_d = level_q + 1'b1;
        else if (!do_wr && do_rd) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/adc_byte_packer.sv
// Packs pairs of ADC bytes into 16-bit words and buffers them for a downstream writer.
// Define PACKER_DROP_CNT_EN to add the drop_cnt output counting bytes lost to overflow.
module adc_byte_packer
    import adc_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter bit         LOW_FIRST  = 1'b1,
    parameter logic [7:0] PAD_BYTE   = PAD_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    adc_byte_packer_if.slave  bus
`ifdef PACKER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    pair_state_e state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] word_q, word_d;
    logic        push_q, push_d;
    logic        ovf_q, ovf_d;

    logic [15:0]      fifo_data;
    logic             fifo_valid;
    logic             fifo_full;
    logic [LVL_W-1:0] fifo_level;
    logic             pop;
    logic             drop;

    // A formed word sits in word_q for one cycle before it is written, so a
    // word completed at edge N is visible at the head after edge N+1.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        word_d  = word_q;
        push_d  = 1'b0;
        unique case (state_q)
            WAIT_FIRST: begin
                if (bus.in_valid) begin
                    hold_d  = bus.in_data;
                    state_d = WAIT_SECOND;
                end
            end
            WAIT_SECOND: begin
                if (bus.in_valid) begin
                    word_d  = LOW_FIRST ? {bus.in_data, hold_q} : {hold_q, bus.in_data};
                    push_d  = 1'b1;
                    state_d = WAIT_FIRST;
                end else if (bus.flush) begin
                    word_d  = LOW_FIRST ? {PAD_BYTE, hold_q} : {hold_q, PAD_BYTE};
                    push_d  = 1'b1;
                    state_d = WAIT_FIRST;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    assign pop  = fifo_valid && bus.out_ready;
    assign drop = push_q && fifo_full && !pop;

    always_comb begin
        ovf_d = ovf_q;
        if (bus.ovf_clr) ovf_d = 1'b0;
        if (drop)        ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_FIRST;
            hold_q  <= 8'h00;
            word_q  <= 16'h0000;
            push_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            word_q  <= word_d;
            push_q  <= push_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef PACKER_DROP_CNT_EN
    // A padded word carries only one real byte, so it counts as one.
    logic                  pad_q, pad_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pad_d      = (state_q == WAIT_SECOND) && !bus.in_valid && bus.flush;
        drop_cnt_d = bus.ovf_clr ? '0 : drop_cnt_q;
        if (drop) drop_cnt_d = sat_add(drop_cnt_d, pad_q ? 2'd1 : 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pad_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pad_q      <= pad_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (push_q),
        .wr_data  (word_q),
        .rd_en    (bus.out_ready),
        .rd_data  (fifo_data),
        .rd_valid (fifo_valid),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    assign bus.out_data  = fifo_data;
    assign bus.out_valid = fifo_valid;
    assign bus.level     = fifo_level;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_adc_byte_packer.sv
// Directed bench for adc_byte_packer: one LOW_FIRST=1 and one LOW_FIRST=0 instance, depth 8.
module tb_adc_byte_packer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adc_byte_packer_if #(.FIFO_DEPTH(8)) ia ();
    adc_byte_packer_if #(.FIFO_DEPTH(8)) ib ();

`ifdef PACKER_DROP_CNT_EN
    logic [15:0] dca, dcb;
`endif

    adc_byte_packer #(.FIFO_DEPTH(8), .LOW_FIRST(1'b1), .PAD_BYTE(8'h00)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
`ifdef PACKER_DROP_CNT_EN
        ,
        .drop_cnt (dca)
`endif
    );

    adc_byte_packer #(.FIFO_DEPTH(8), .LOW_FIRST(1'b0), .PAD_BYTE(8'h00)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
`ifdef PACKER_DROP_CNT_EN
        ,
        .drop_cnt (dcb)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        ia.in_data  = b;
        ia.in_valid = 1'b1;
        tick();
        ia.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        ib.in_data  = b;
        ib.in_valid = 1'b1;
        tick();
        ib.in_valid = 1'b0;
    endtask

    logic [15:0] exp_drain [8];
    logic [15:0] q [$];
    logic [15:0] front;
    logic [7:0]  lo, hi;
    int          sent, popped, cyc;
    bit          second;

    initial begin
        exp_drain = '{16'h1312, 16'h1514, 16'h1716, 16'h1918,
                      16'h1b1a, 16'h1d1c, 16'h1f1e, 16'he1e0};
        reset = 1'b1;
        ia.in_data = 8'h00; ia.in_valid = 1'b0; ia.flush = 1'b0; ia.out_ready = 1'b1; ia.ovf_clr = 1'b0;
        ib.in_data = 8'h00; ib.in_valid = 1'b0; ib.flush = 1'b0; ib.out_ready = 1'b1; ib.ovf_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", ia.out_valid, 1'b0);
        chk("rst_data",  ia.out_data, 16'h0000);
        chk("rst_level", ia.level, 4'd0);
        chk("rst_ovf",   ia.ovf, 1'b0);
        chk("rst_b_valid", ib.out_valid, 1'b0);
`ifdef PACKER_DROP_CNT_EN
        chk("rst_dcnt", dca, 16'h0000);
`endif

        // Basic pair, low byte first, one-cycle word with ready high
        send_a(8'h34);
        send_a(8'h12);
        chk("pair_not_yet", ia.out_valid, 1'b0);
        tick();
        chk("pair_valid", ia.out_valid, 1'b1);
        chk("pair_data",  ia.out_data, 16'h1234);
        chk("pair_level", ia.level, 4'd1);
        tick();
        chk("pair_gone_valid", ia.out_valid, 1'b0);
        chk("pair_gone_data",  ia.out_data, 16'h0000);

        // High byte first, then a padded flush
        send_b(8'hAB);
        send_b(8'hCD);
        tick();
        chk("hf_data", ib.out_data, 16'hABCD);
        tick();
        send_b(8'h77);
        ib.flush = 1'b1;
        tick();
        ib.flush = 1'b0;
        tick();
        chk("hf_flush_valid", ib.out_valid, 1'b1);
        chk("hf_flush_data",  ib.out_data, 16'h7700);
        tick();

        // Flush while waiting for a first byte does nothing
        ia.flush = 1'b1;
        tick();
        ia.flush = 1'b0;
        tick(); tick();
        chk("flush_idle_level", ia.level, 4'd0);
        chk("flush_idle_valid", ia.out_valid, 1'b0);

        // Flush together with the second byte completes the word normally
        send_a(8'h11);
        ia.in_data = 8'h22; ia.in_valid = 1'b1; ia.flush = 1'b1;
        tick();
        ia.in_valid = 1'b0; ia.flush = 1'b0;
        tick();
        chk("flush_valid_data", ia.out_data, 16'h2211);
        tick();
        chk("flush_valid_single", ia.out_valid, 1'b0);

        // Padded flush, low byte first
        send_a(8'h99);
        ia.flush = 1'b1;
        tick();
        ia.flush = 1'b0;
        tick();
        chk("pad_lf_data", ia.out_data, 16'h0099);
        tick();

        // Fill with 18 bytes and no ready: 8 words kept, 9th dropped
        ia.out_ready = 1'b0;
        for (int i = 0; i < 18; i++) send_a(8'(8'h10 + i));
        tick(); tick();
        chk("fill_level", ia.level, 4'd8);
        chk("fill_ovf",   ia.ovf, 1'b1);
        chk("fill_head",  ia.out_data, 16'h1110);
`ifdef PACKER_DROP_CNT_EN
        chk("fill_dcnt", dca, 16'd2);
`endif
        ia.ovf_clr = 1'b1;
        tick();
        ia.ovf_clr = 1'b0;
        chk("clr_ovf", ia.ovf, 1'b0);
`ifdef PACKER_DROP_CNT_EN
        chk("clr_dcnt", dca, 16'd0);
`endif

        // Full buffer: push and pop on the same edge
        send_a(8'hE0);
        send_a(8'hE1);
        ia.out_ready = 1'b1;
        tick();
        ia.out_ready = 1'b0;
        chk("fullpp_level", ia.level, 4'd8);
        chk("fullpp_ovf",   ia.ovf, 1'b0);
        chk("fullpp_head",  ia.out_data, 16'h1312);

        // New overflow on the same edge as ovf_clr: set wins
        send_a(8'hF0);
        send_a(8'hF1);
        ia.ovf_clr = 1'b1;
        tick();
        ia.ovf_clr = 1'b0;
        chk("clr_vs_set_ovf", ia.ovf, 1'b1);
        chk("clr_vs_set_level", ia.level, 4'd8);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), ia.out_data, exp_drain[i]);
            ia.out_ready = 1'b1;
            tick();
            ia.out_ready = 1'b0;
        end
        chk("drain_empty_valid", ia.out_valid, 1'b0);
        chk("drain_empty_level", ia.level, 4'd0);

        // Reset mid-pair discards the held byte and overrides a same-cycle byte
        ia.out_ready = 1'b1;
        send_a(8'h55);
        reset = 1'b1;
        ia.in_data = 8'h66; ia.in_valid = 1'b1;
        tick();
        reset = 1'b0;
        ia.in_valid = 1'b0;
        chk("midrst_level", ia.level, 4'd0);
        chk("midrst_ovf",   ia.ovf, 1'b0);
        send_a(8'h01);
        send_a(8'h02);
        tick();
        chk("midrst_data",  ia.out_data, 16'h0201);
        chk("midrst_level1", ia.level, 4'd1);
        tick();
        chk("midrst_single", ia.out_valid, 1'b0);

        // 20 words through depth 8 with random ready: pointers wrap
        sent = 0; popped = 0; cyc = 0; second = 1'b0;
        while (popped < 20 && cyc < 2000) begin
            ia.out_ready = 1'($urandom_range(0, 1));
            if (ia.out_valid && ia.out_ready) begin
                if (q.size() == 0) begin
                    chk("wrap_extra", ia.out_valid, 1'b0);
                end else begin
                    front = q.pop_front();
                    chk("wrap_word", ia.out_data, front);
                end
                popped++;
            end
            ia.in_valid = 1'b0;
            if (sent < 20 && ia.level < 4'd5) begin
                if (!second) begin
                    lo = 8'(sent * 2) ^ 8'h5A;
                    ia.in_data = lo; ia.in_valid = 1'b1; second = 1'b1;
                end else begin
                    hi = 8'(sent * 2 + 1) ^ 8'hA5;
                    ia.in_data = hi; ia.in_valid = 1'b1; second = 1'b0;
                    q.push_back({hi, lo});
                    sent++;
                end
            end
            tick();
            cyc++;
        end
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b0;
        chk("wrap_count", popped, 20);
        chk("wrap_ovf", ia.ovf, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_byte_packer.md
ADC_BYTE_PACKER -- requirements
Module: adc_byte_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set word-buffer depth; power of two, 4..64.
REQ-002 Parameter LOW_FIRST, default 1, SHALL make the first byte of a pair the low byte; 0 makes it the high byte.
REQ-003 Parameter PAD_BYTE, default 8'h00, SHALL be the filler byte used by flush.
REQ-004 Ports SHALL be:
clk  in  1  single clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
in_data  in  8  ADC byte
in_valid  in  1  in_data is valid this cycle; no backpressure
flush  in  1  pulse: emit a pending half-word padded
out_data  out  16  head-of-buffer word, toward the slave FIFO writer
out_valid  out  1  out_data is valid
out_ready  in  1  consumer takes the word when out_valid && out_ready
level  out  $clog2(FIFO_DEPTH)+1  words buffered
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf
drop_cnt  out  16  bytes dropped; present only with PACKER_DROP_CNT_EN

Function
REQ-005 Pair FSM SHALL have states WAIT_FIRST and WAIT_SECOND; reset enters WAIT_FIRST.
REQ-006 In WAIT_FIRST, in_valid SHALL latch in_data into the hold register and move to WAIT_SECOND.
REQ-007 In WAIT_SECOND, in_valid SHALL form a word and push it, then return to WAIT_FIRST. With LOW_FIRST=1 the word is {in_data, hold}; with LOW_FIRST=0 it is {hold, in_data}.
REQ-008 In WAIT_SECOND, flush with in_valid low SHALL push the hold byte with PAD_BYTE in the second-byte position, then return to WAIT_FIRST.
REQ-009 flush in WAIT_FIRST SHALL have no effect.
REQ-010 flush together with in_valid in WAIT_SECOND SHALL complete the word normally and ignore flush.
REQ-011 The buffer SHALL be show-ahead; out_data and out_valid are driven from the head entry.
REQ-012 Latency: a word pushed at edge N into an empty buffer SHALL give out_valid=1 after edge N+1.
REQ-013 A pop SHALL occur when out_valid && out_ready. The next entry, if any, SHALL appear after the same edge.
REQ-014 A push when level==FIFO_DEPTH with no pop in the same cycle SHALL drop the word, set ovf, and leave the buffer unchanged. The FSM SHALL still return to WAIT_FIRST.
REQ-015 A push when level==FIFO_DEPTH with a pop in the same cycle SHALL be accepted; level stays unchanged.
REQ-016 A simultaneous push and pop on a non-empty buffer SHALL leave level unchanged; an empty buffer never pops.
REQ-017 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 out_data SHALL be 16'h0000 whenever out_valid=0.
REQ-019 ovf_clr SHALL clear ovf; if a set and ovf_clr occur in the same cycle, set SHALL win.

Reset
REQ-020 reset SHALL force: FSM to WAIT_FIRST, hold=0, pointers=0, level=0, out_valid=0, out_data=0, ovf=0, drop_cnt=0.
REQ-021 reset mid-pair SHALL discard the held byte. reset SHALL override every other input in the same cycle.

Configuration
REQ-022 With PACKER_DROP_CNT_EN defined, drop_cnt SHALL add 2 per dropped word, add 1 per dropped flushed word, saturate at 16'hFFFF, and clear on ovf_clr.
REQ-023 Without PACKER_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-024 Shared package adc_pkg SHALL hold the FSM state enum, default PAD_BYTE, and the DROP_CNT_W=16 constant.
REQ-025 The buffer SHALL be a sub-module sync_word_fifo, with 16-bit width, parameterized depth, show-ahead output, and a level output. The pair FSM, overflow logic and counter SHALL live in the top module.

Verification
REQ-026 Reset, then bytes 0x34, 0x12 on consecutive cycles with out_ready=1 -> out_data=16'h1234, out_valid for one cycle, starting one edge after the second byte.
REQ-027 LOW_FIRST=0, bytes 0xAB, 0xCD -> 16'hABCD; then byte 0x77 + flush -> 16'h7700.
REQ-028 out_ready=0, 18 bytes, FIFO_DEPTH=8 -> level=8, ovf=1, drop_cnt=2 (macro on); drain yields the first 8 words in order.
REQ-029 Buffer full, with a push and a pop in the same cycle -> level stays 8, no ovf; ovf_clr asserted together with a new overflow -> ovf remains 1.
REQ-030 Byte 0x55, reset pulse, then bytes 0x01, 0x02 -> single word 16'h0201, 0x55 never emitted; pointer wrap checked over 20 words with random out_ready.
